axis_m_burst: RTL
=================

# axis_m_burst

AXI-Stream master that transmits a burst of incrementing 32-bit words with `tlast` on the final beat, then pulses `finish`. It is the transmit end paired with the team's single-word AXI-Stream slave and with downstream stream consumers. It sits between a user control port (start, base value, length) and the AXI-Stream `t*` channel, and honours back-pressure on every beat.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of `tdata` and `base`
- `LEN_WIDTH`, 8, width of `length`; max burst = 2^LEN_WIDTH − 1 beats

Ports:
- `aclk`  in  1  clock, all logic on rising edge
- `areset`  in  1  asynchronous, active-high reset
- `start`  in  1  request a burst; sampled only in IDLE
- `base`  in  DATA_WIDTH  first word of the burst; latched with `start`
- `length`  in  LEN_WIDTH  beats in the burst; latched with `start`
- `busy`  out  1  high from accepted `start` through the `finish` cycle
- `finish`  out  1  one-cycle pulse after the last handshake
- `tvalid`  out  1  AXIS valid
- `tready`  in  1  AXIS ready from slave
- `tdata`  out  DATA_WIDTH  AXIS data
- `tlast`  out  1  AXIS last, high only with the final beat

## Operation
- Reset values: `tvalid`=0, `tlast`=0, `tdata`=0, `finish`=0, `busy`=0, state IDLE, beat counter 0.
- FSM states: IDLE, SEND, DONE.
- IDLE: on `start`=1 with `length`≠0, latch `base` into `tdata`, load remaining = `length`, assert `tvalid`, assert `busy`, and set `tlast`=(`length`==1). Go to SEND. `start` with `length`=0 is ignored: no beats, no `finish`, `busy` stays 0.
- SEND: handshake = `tvalid & tready`. On each handshake, remaining decrements. If it was not the last beat, `tdata` <= `tdata`+1 (mod 2^DATA_WIDTH; wraps from all-ones to 0), and `tlast` <= (remaining after decrement == 1). On the last handshake, `tvalid`/`tlast` <= 0 and the FSM goes to DONE.
- DONE: `finish`=1 for exactly this cycle, `busy` still 1; unconditionally return to IDLE.
- `start` is ignored in SEND and DONE. `base`/`length` changes after latch have no effect.
- AXIS rules: `tvalid` never depends combinationally on `tready`. Once asserted, `tvalid`, `tdata` and `tlast` hold stable until handshake. `tvalid` stays high with no gaps between beats of one burst.

## Timing
- `start` sampled at edge N → `tvalid`=1, `tdata`=`base` visible after edge N.
- With `tready` held 1: one beat per cycle; a burst of L beats completes handshakes at edges N+1..N+L; `finish`=1 during cycle after edge N+L; next `start` is accepted at edge N+L+2.
- Stall: `tready`=0 for k cycles on any beat adds exactly k cycles; no beat lost or duplicated.
- `tready` high while `tvalid` low: no effect.
- Async reset mid-burst: all outputs go to reset values immediately, without waiting for a clock edge. The burst is abandoned, with no `finish` pulse. After deassertion the block is in IDLE.

## Structure
- Shared package `axis_pkg`: default `DATA_WIDTH`, FSM state enum (IDLE/SEND/DONE), handshake helper definition.
- One natural sub-module, `axis_beat_cnt`: a loadable down-counter with `load`, `dec`, `is_last` (count==1) and `is_zero` outputs, parameterised on `LEN_WIDTH`.

## Test plan
- `base`=0x100, `length`=4, `tready`=1 → `tdata` 0x100,0x101,0x102,0x103 on 4 consecutive cycles; `tlast` only on 0x103; `finish` one cycle later.
- Same burst with `tready` toggling 1,0,0,1,… → the same 4 words in order; `tdata`/`tlast` stable during stalls; no `tvalid` drop mid-burst.
- `length`=1, `base`=0xDEADBEEF → a single beat with `tlast`=1; `finish` pulse; `busy` high for 2 cycles with `tready`=1.
- `base`=0xFFFFFFFE, `length`=3 → 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, with `tlast` on 0x0.
- `length`=0 with `start`, and also `start` pulsed during SEND → no extra beats, no extra `finish`, in-flight burst unchanged.
- `areset` asserted between clock edges on beat 2 of 5 → `tvalid`/`busy` drop at once without a clock edge; no `finish`; a new `start` after release sends a full burst.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: default widths, burst FSM state encoding
// and the valid/ready handshake helper.
package axis_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // A beat transfers on a clock edge where both valid and ready are high.
  function automatic logic axis_handshake(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/axis_beat_cnt.sv
// Loadable down-counter tracking how many beats of the burst remain.
// A decrement at zero holds at zero; load wins over decrement.
module axis_beat_cnt #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 load,
  input  logic [LEN_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic [LEN_WIDTH-1:0] count,
  output logic                 is_last,
  output logic                 is_zero
);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - LEN_WIDTH'(1);
    end
  end

  assign is_last = (count == LEN_WIDTH'(1));
  assign is_zero = (count == '0);

endmodule

// File: rtl/axis_m_burst.sv
// AXI-Stream master sending a burst of incrementing words with tlast on the
// final beat, then a one-cycle finish pulse.
//
// Handshake: a beat transfers on a rising edge where tvalid & tready are both
// high. tvalid is a register and never depends on tready; once raised,
// tvalid/tdata/tlast hold until that beat transfers, and tvalid stays high
// without gaps for the whole burst.
module axis_m_burst
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  finish,
  output logic                  tvalid,
  input  logic                  tready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tlast,
  output state_t                dbg_state
);

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] tdata_n;
  logic                  tvalid_n;
  logic                  tlast_n;
  logic                  hs;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic [LEN_WIDTH-1:0]  cnt_count;
  logic                  cnt_last;
  logic                  cnt_zero;

  axis_beat_cnt #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_beat_cnt (
    .aclk     (aclk),
    .areset   (areset),
    .load     (cnt_load),
    .load_val (length),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .is_last  (cnt_last),
    .is_zero  (cnt_zero)
  );

  assign hs = axis_handshake(tvalid, tready);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else begin
      state  <= state_n;
      tdata  <= tdata_n;
      tvalid <= tvalid_n;
      tlast  <= tlast_n;
    end
  end

  always_comb begin
    state_n  = state;
    tdata_n  = tdata;
    tvalid_n = tvalid;
    tlast_n  = tlast;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      IDLE: begin
        // A zero-length request is dropped entirely.
        if (start && (length != '0)) begin
          tdata_n  = base;
          tvalid_n = 1'b1;
          tlast_n  = (length == LEN_WIDTH'(1));
          cnt_load = 1'b1;
          state_n  = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          cnt_dec = 1'b1;
          // An empty counter here can only mean a lost count; close the burst.
          if (cnt_last || cnt_zero) begin
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            state_n  = DONE;
          end else begin
            tdata_n = tdata + DATA_WIDTH'(1);
            tlast_n = (cnt_count == LEN_WIDTH'(2));
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign finish    = (state == DONE);
  assign dbg_state = state;

endmodule
